// File: rtl/clic_gateway_array.sv
// Per-source CLIC interrupt gateway: input synchronizers, level/edge trigger
// handling with polarity, and the pending (clicintip) bits fed to the arbiter.
module clic_gateway_array #(
  parameter int unsigned N_SOURCE    = 256,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SrcWidth   = $clog2(N_SOURCE)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_SOURCE-1:0]      intr_src_i,
  input  logic [N_SOURCE-1:0][1:0] trig_i,
  input  logic [N_SOURCE-1:0]      claim_i,
  input  logic                     sw_we_i,
  input  logic [SrcWidth-1:0]      sw_idx_i,
  input  logic                     sw_ip_i,
  output logic                     sw_ip_o,
  output logic [N_SOURCE-1:0]      ip_o,
  output logic [N_SOURCE-1:0]      le_o
);

  logic [N_SOURCE-1:0] sync_out;
  logic [N_SOURCE-1:0] prev_q;
  logic [N_SOURCE-1:0] ip_q;
  logic [N_SOURCE-1:0] ip_d;
  logic [N_SOURCE-1:0] edge_det;
  logic                sw_in_range;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_out = intr_src_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][N_SOURCE-1:0] sync_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= intr_src_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
  end

  // Edges use the raw synced value, so the zero reset state of prev_q never
  // looks like a falling edge on a negative-polarity line.
  always_comb begin
    for (int i = 0; i < N_SOURCE; i++) begin
      le_o[i]     = trig_i[i][0];
      edge_det[i] = trig_i[i][1] ? (~sync_out[i] & prev_q[i]) : (sync_out[i] & ~prev_q[i]);
      ip_d[i]     = ip_q[i];
      if (!trig_i[i][0]) begin
        ip_d[i] = sync_out[i] ^ trig_i[i][1];
      end else if (edge_det[i]) begin
        ip_d[i] = 1'b1;
      end else if (sw_we_i && (sw_idx_i == SrcWidth'(i))) begin
        ip_d[i] = sw_ip_i;
      end else if (claim_i[i]) begin
        ip_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
      ip_q   <= '0;
    end else begin
      prev_q <= sync_out;
      ip_q   <= ip_d;
    end
  end

  assign sw_in_range = (32'(sw_idx_i) < N_SOURCE);
  assign sw_ip_o     = sw_in_range ? ip_q[sw_idx_i] : 1'b0;
  assign ip_o        = ip_q;

endmodule

// File: tb/tb_clic_gateway_array.sv
// Directed bench for clic_gateway_array: a full 256-source instance plus a
// 20-source instance so that out-of-range software indices are representable.
module tb_clic_gateway_array;

  logic              clk;
  logic              rst;
  logic [255:0]      intr;
  logic [255:0][1:0] trig;
  logic [255:0]      claim;
  logic              sw_we;
  logic [7:0]        sw_idx;
  logic              sw_ip;
  logic              sw_ip_out;
  logic [255:0]      ip;
  logic [255:0]      le;

  logic [19:0]       intr_s;
  logic [19:0][1:0]  trig_s;
  logic [19:0]       claim_s;
  logic              sw_we_s;
  logic [4:0]        sw_idx_s;
  logic              sw_ip_s;
  logic              sw_ip_out_s;
  logic [19:0]       ip_s;
  logic [19:0]       le_s;

  int checks = 0;
  int errors = 0;

  clic_gateway_array #(.N_SOURCE(256), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .intr_src_i (intr),
    .trig_i     (trig),
    .claim_i    (claim),
    .sw_we_i    (sw_we),
    .sw_idx_i   (sw_idx),
    .sw_ip_i    (sw_ip),
    .sw_ip_o    (sw_ip_out),
    .ip_o       (ip),
    .le_o       (le)
  );

  clic_gateway_array #(.N_SOURCE(20), .SYNC_STAGES(2)) dut_small (
    .clk_i      (clk),
    .rst_i      (rst),
    .intr_src_i (intr_s),
    .trig_i     (trig_s),
    .claim_i    (claim_s),
    .sw_we_i    (sw_we_s),
    .sw_idx_i   (sw_idx_s),
    .sw_ip_i    (sw_ip_s),
    .sw_ip_o    (sw_ip_out_s),
    .ip_o       (ip_s),
    .le_o       (le_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [255:0] exp_le;
    rst      = 1'b1;
    intr     = '0;
    trig     = '0;
    claim    = '0;
    sw_we    = 1'b0;
    sw_idx   = '0;
    sw_ip    = 1'b0;
    intr_s   = '0;
    trig_s   = {20{2'b01}};
    claim_s  = '0;
    sw_we_s  = 1'b0;
    sw_idx_s = '0;
    sw_ip_s  = 1'b0;
    trig[7]   = 2'b01;
    trig[9]   = 2'b01;
    trig[12]  = 2'b01;
    trig[3]   = 2'b11;
    trig[0]   = 2'b11;
    trig[100] = 2'b11;
    trig[255] = 2'b11;
    intr[3]   = 1'b1;
    intr[0]   = 1'b1;
    intr[100] = 1'b1;
    intr[255] = 1'b1;
    tick(1);
    checks++;
    if (ip !== '0) begin
      errors++;
      $display("FAIL reset_ip: got %h want 0", ip);
    end
    exp_le      = '0;
    exp_le[0]   = 1'b1;
    exp_le[3]   = 1'b1;
    exp_le[7]   = 1'b1;
    exp_le[9]   = 1'b1;
    exp_le[12]  = 1'b1;
    exp_le[100] = 1'b1;
    exp_le[255] = 1'b1;
    checks++;
    if (le !== exp_le) begin
      errors++;
      $display("FAIL reset_le: got %h want %h", le, exp_le);
    end
    for (int i = 0; i < 256; i++) begin
      sw_idx = 8'(i);
      #1;
      checks++;
      if (sw_ip_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_sw_ip idx %0d: got %b want 0", i, sw_ip_out);
      end
    end
    tick(1);
    rst = 1'b0;
    tick(5);
    // Negative-polarity lines held high from reset must not become pending.
    checks++;
    if (ip !== '0) begin
      errors++;
      $display("FAIL post_reset_ip: got %h want 0", ip);
    end
  endtask

  task automatic test_level;
    intr[5] = 1'b1;
    tick(2);
    checks++;
    if (ip[5] !== 1'b0) begin
      errors++;
      $display("FAIL level_early: got %b want 0", ip[5]);
    end
    tick(1);
    checks++;
    if (ip[5] !== 1'b1) begin
      errors++;
      $display("FAIL level_assert: got %b want 1", ip[5]);
    end
    claim[5] = 1'b1;
    tick(1);
    claim[5] = 1'b0;
    checks++;
    if (ip[5] !== 1'b1) begin
      errors++;
      $display("FAIL level_claim: got %b want 1", ip[5]);
    end
    intr[5] = 1'b0;
    tick(2);
    checks++;
    if (ip[5] !== 1'b1) begin
      errors++;
      $display("FAIL level_drop_early: got %b want 1", ip[5]);
    end
    tick(1);
    checks++;
    if (ip[5] !== 1'b0) begin
      errors++;
      $display("FAIL level_drop: got %b want 0", ip[5]);
    end
  endtask

  task automatic test_edge_pos;
    intr[7] = 1'b1;
    tick(1);
    intr[7] = 1'b0;
    tick(1);
    checks++;
    if (ip[7] !== 1'b0) begin
      errors++;
      $display("FAIL edge_pos_early: got %b want 0", ip[7]);
    end
    tick(1);
    checks++;
    if (ip[7] !== 1'b1) begin
      errors++;
      $display("FAIL edge_pos_set: got %b want 1", ip[7]);
    end
    tick(7);
    checks++;
    if (ip[7] !== 1'b1) begin
      errors++;
      $display("FAIL edge_pos_hold: got %b want 1", ip[7]);
    end
    claim[7] = 1'b1;
    tick(1);
    claim[7] = 1'b0;
    checks++;
    if (ip[7] !== 1'b0) begin
      errors++;
      $display("FAIL edge_pos_claim: got %b want 0", ip[7]);
    end
  endtask

  task automatic test_edge_neg;
    intr[3] = 1'b0;
    tick(2);
    checks++;
    if (ip[3] !== 1'b0) begin
      errors++;
      $display("FAIL edge_neg_early: got %b want 0", ip[3]);
    end
    tick(1);
    checks++;
    if (ip[3] !== 1'b1) begin
      errors++;
      $display("FAIL edge_neg_set: got %b want 1", ip[3]);
    end
    intr[3] = 1'b1;
    tick(4);
    checks++;
    if (ip[3] !== 1'b1) begin
      errors++;
      $display("FAIL edge_neg_rise: got %b want 1", ip[3]);
    end
  endtask

  task automatic test_collision;
    // Edge detected in the same cycle as a claim.
    intr[9] = 1'b1;
    tick(2);
    claim[9] = 1'b1;
    tick(1);
    claim[9] = 1'b0;
    checks++;
    if (ip[9] !== 1'b1) begin
      errors++;
      $display("FAIL coll_edge_claim: got %b want 1", ip[9]);
    end
    intr[9] = 1'b0;
    tick(3);
    claim[9] = 1'b1;
    tick(1);
    claim[9] = 1'b0;
    checks++;
    if (ip[9] !== 1'b0) begin
      errors++;
      $display("FAIL coll_clear: got %b want 0", ip[9]);
    end
    // Edge detected in the same cycle as a software write of 0.
    intr[9] = 1'b1;
    tick(2);
    sw_we  = 1'b1;
    sw_idx = 8'd9;
    sw_ip  = 1'b0;
    tick(1);
    sw_we = 1'b0;
    checks++;
    if (ip[9] !== 1'b1) begin
      errors++;
      $display("FAIL coll_edge_sw0: got %b want 1", ip[9]);
    end
    intr[9] = 1'b0;
    tick(3);
    sw_we  = 1'b1;
    sw_ip  = 1'b0;
    claim[9] = 1'b1;
    tick(1);
    checks++;
    if (ip[9] !== 1'b0) begin
      errors++;
      $display("FAIL coll_sw0_claim: got %b want 0", ip[9]);
    end
    sw_ip = 1'b1;
    tick(1);
    sw_we    = 1'b0;
    claim[9] = 1'b0;
    checks++;
    if (ip[9] !== 1'b1) begin
      errors++;
      $display("FAIL coll_sw1_claim: got %b want 1", ip[9]);
    end
  endtask

  task automatic test_sw_access;
    sw_idx = 8'd12;
    sw_ip  = 1'b1;
    sw_we  = 1'b1;
    #1;
    checks++;
    if (sw_ip_out !== 1'b0) begin
      errors++;
      $display("FAIL sw_before: got %b want 0", sw_ip_out);
    end
    tick(1);
    sw_we = 1'b0;
    checks++;
    if (sw_ip_out !== 1'b1 || ip[12] !== 1'b1) begin
      errors++;
      $display("FAIL sw_write1: got sw_ip %b ip %b want 1 1", sw_ip_out, ip[12]);
    end
    // Switching to level mode with the line low drops the bit; writes are ignored.
    trig[12] = 2'b00;
    tick(1);
    sw_we = 1'b1;
    tick(1);
    sw_we = 1'b0;
    checks++;
    if (sw_ip_out !== 1'b0 || ip[12] !== 1'b0) begin
      errors++;
      $display("FAIL sw_level: got sw_ip %b ip %b want 0 0", sw_ip_out, ip[12]);
    end
    sw_we_s  = 1'b1;
    sw_idx_s = 5'd19;
    sw_ip_s  = 1'b1;
    tick(1);
    sw_idx_s = 5'd21;
    sw_ip_s  = 1'b1;
    #1;
    checks++;
    if (sw_ip_out_s !== 1'b0) begin
      errors++;
      $display("FAIL sw_oor_read: got %b want 0", sw_ip_out_s);
    end
    tick(1);
    sw_ip_s = 1'b0;
    tick(1);
    sw_we_s = 1'b0;
    checks++;
    if (ip_s !== 20'h80000 || sw_ip_out_s !== 1'b0) begin
      errors++;
      $display("FAIL sw_oor_write: got ip %h sw_ip %b want 80000 0", ip_s, sw_ip_out_s);
    end
  endtask

  task automatic test_reset_mid;
    intr[0]   = 1'b0;
    intr[100] = 1'b0;
    intr[255] = 1'b0;
    tick(1);
    intr[0]   = 1'b1;
    intr[100] = 1'b1;
    intr[255] = 1'b1;
    tick(3);
    checks++;
    if ({ip[255], ip[100], ip[0]} !== 3'b111) begin
      errors++;
      $display("FAIL mid_pending: got %b want 111", {ip[255], ip[100], ip[0]});
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (ip !== '0 || ip_s !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %h / %h want 0", ip, ip_s);
    end
    tick(6);
    checks++;
    if (ip !== '0) begin
      errors++;
      $display("FAIL mid_retrigger: got %h want 0", ip);
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_pos();
    test_edge_neg();
    test_collision();
    test_sw_access();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
